// File: rtl/dds_mod_ctrl.sv
// dds_mod_ctrl: symbol-rate sequencer that holds the DDS in a BASK/BFSK/BPSK
// configuration for a programmed number of sample clocks per accepted data bit.
module dds_mod_ctrl #(
    parameter int               INC_W  = 6,
    parameter logic [INC_W-1:0] F0_INC = 6'd1,
    parameter logic [INC_W-1:0] F1_INC = 6'd2,
    parameter int               LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [LEN_W-1:0] i_sym_len,
    input  logic             i_sym_valid,
    input  logic             i_sym_data,
    output logic             o_sym_ready,
    output logic             o_dds_en,
    output logic             o_dds_clr,
    output logic [INC_W-1:0] o_phase_inc,
    output logic             o_invert,
    output logic             o_amp_gate,
    output logic             o_sym_strobe,
    output logic             o_busy,
    output logic             o_underrun
);

    // state | meaning
    // IDLE  | not transmitting, waiting for start
    // FETCH | DDS parked, waiting for the first symbol or recovering from underrun
    // RUN   | DDS running, counting down the current symbol
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BFSK = 2'b01;
    localparam logic [1:0] MODE_BPSK = 2'b10;

    state_t             r_state, w_state_nx;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nx;
    logic [LEN_W-1:0]   r_len, w_len_nx;
    logic [1:0]         r_mode, w_mode_nx;
    logic               r_stop_pend, w_stop_pend_nx;
    logic               r_dds_en, w_dds_en_nx;
    logic               r_dds_clr, w_dds_clr_nx;
    logic [INC_W-1:0]   r_phase_inc, w_phase_inc_nx;
    logic               r_invert, w_invert_nx;
    logic               r_amp_gate, w_amp_gate_nx;
    logic               r_sym_strobe, w_sym_strobe_nx;
    logic               r_busy, w_busy_nx;
    logic               r_underrun, w_underrun_nx;

    logic               w_ready;
    logic               w_hs;
    logic               w_cnt_zero;
    logic               w_load;
    logic [INC_W-1:0]   w_cfg_inc;
    logic               w_cfg_inv;
    logic               w_cfg_amp;

    assign w_cnt_zero = (r_cnt == '0);

    // Ready is decoded from registered state so a same-cycle stop can veto the boundary accept.
    assign w_ready = (r_state == S_FETCH) ||
                     ((r_state == S_RUN) && w_cnt_zero && !r_stop_pend && !i_stop);
    assign w_hs    = i_sym_valid & w_ready;

    always_comb begin
        w_cfg_inc = F1_INC;
        w_cfg_inv = 1'b0;
        w_cfg_amp = 1'b1;
        case (r_mode)
            MODE_BFSK: w_cfg_inc = i_sym_data ? F1_INC : F0_INC;
            MODE_BPSK: w_cfg_inv = i_sym_data;
            default:   w_cfg_amp = i_sym_data;
        endcase
    end

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_len_nx        = r_len;
        w_mode_nx       = r_mode;
        w_stop_pend_nx  = r_stop_pend;
        w_dds_en_nx     = r_dds_en;
        w_dds_clr_nx    = 1'b0;
        w_phase_inc_nx  = r_phase_inc;
        w_invert_nx     = r_invert;
        w_amp_gate_nx   = r_amp_gate;
        w_sym_strobe_nx = 1'b0;
        w_underrun_nx   = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_mode_nx      = i_mode;
                    w_len_nx       = (i_sym_len == '0) ? LEN_W'(1) : i_sym_len;
                    w_stop_pend_nx = 1'b0;
                    w_dds_clr_nx   = 1'b1;
                    w_state_nx     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_hs) begin
                    w_load         = 1'b1;
                    w_stop_pend_nx = i_stop;
                    w_state_nx     = S_RUN;
                end else if (i_stop) begin
                    w_stop_pend_nx = 1'b0;
                    w_dds_en_nx    = 1'b0;
                    w_amp_gate_nx  = 1'b0;
                    w_invert_nx    = 1'b0;
                    w_state_nx     = S_IDLE;
                end
            end
            S_RUN: begin
                if (!w_cnt_zero) begin
                    w_cnt_nx = r_cnt - LEN_W'(1);
                    if (i_stop) begin
                        w_stop_pend_nx = 1'b1;
                    end
                end else if (r_stop_pend || i_stop) begin
                    w_stop_pend_nx = 1'b0;
                    w_dds_en_nx    = 1'b0;
                    w_amp_gate_nx  = 1'b0;
                    w_invert_nx    = 1'b0;
                    w_state_nx     = S_IDLE;
                end else if (w_hs) begin
                    w_load = 1'b1;
                end else begin
                    w_underrun_nx = 1'b1;
                    w_dds_en_nx   = 1'b0;
                    w_amp_gate_nx = 1'b0;
                    w_state_nx    = S_FETCH;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_load) begin
            w_cnt_nx        = r_len - LEN_W'(1);
            w_phase_inc_nx  = w_cfg_inc;
            w_invert_nx     = w_cfg_inv;
            w_amp_gate_nx   = w_cfg_amp;
            w_dds_en_nx     = 1'b1;
            w_sym_strobe_nx = 1'b1;
        end

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_len        <= '0;
            r_mode       <= '0;
            r_stop_pend  <= 1'b0;
            r_dds_en     <= 1'b0;
            r_dds_clr    <= 1'b0;
            r_phase_inc  <= '0;
            r_invert     <= 1'b0;
            r_amp_gate   <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nx;
            r_len        <= w_len_nx;
            r_mode       <= w_mode_nx;
            r_stop_pend  <= w_stop_pend_nx;
            r_dds_en     <= w_dds_en_nx;
            r_dds_clr    <= w_dds_clr_nx;
            r_phase_inc  <= w_phase_inc_nx;
            r_invert     <= w_invert_nx;
            r_amp_gate   <= w_amp_gate_nx;
            r_sym_strobe <= w_sym_strobe_nx;
            r_busy       <= w_busy_nx;
            r_underrun   <= w_underrun_nx;
        end
    end

    assign o_sym_ready  = w_ready;
    assign o_dds_en     = r_dds_en;
    assign o_dds_clr    = r_dds_clr;
    assign o_phase_inc  = r_phase_inc;
    assign o_invert     = r_invert;
    assign o_amp_gate   = r_amp_gate;
    assign o_sym_strobe = r_sym_strobe;
    assign o_busy       = r_busy;
    assign o_underrun   = r_underrun;

endmodule
